// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a 32-word synchronous data memory.
// Sub-word stores read-modify-write the containing word; loads return the addressed lane extended.
module mem_access_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [7:0]  err_count,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

   state_t      state_reg, state_next;
   logic        write_reg;
   logic        unsigned_reg;
   logic [1:0]  size_reg;
   logic [1:0]  lane_reg;
   logic [31:0] wdata_reg;

   logic        accept;
   logic        bad_req;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;
   logic [31:0] wdata_rep;
   logic [3:0]  byte_en;
   logic [31:0] merge_data;

   assign req_ready = (state_reg == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      bad_req = 1'b0;
      if (req_size == 2'b11)                            bad_req = 1'b1;
      if (req_size == 2'b01 && req_addr[0])             bad_req = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00)  bad_req = 1'b1;
      if (req_addr[31:7] != 25'd0)                      bad_req = 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (bad_req)                state_next = RESP;
               else if (!req_write)        state_next = RD;
               else if (req_size == 2'b10) state_next = WR;
               else                        state_next = RD;
            end
         end
         RD:      state_next = WAIT;
         WAIT:    state_next = RESP;
         WR:      state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Load lane extraction and sign/zero extension.
   always_comb begin
      load_byte = 8'd0;
      case (lane_reg)
         2'd0: load_byte = mem_read_data[7:0];
         2'd1: load_byte = mem_read_data[15:8];
         2'd2: load_byte = mem_read_data[23:16];
         2'd3: load_byte = mem_read_data[31:24];
         default: load_byte = 8'd0;
      endcase
      load_half = lane_reg[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      load_data = mem_read_data;
      case (size_reg)
         2'b00: load_data = unsigned_reg ? {24'd0, load_byte}
                                         : {{24{load_byte[7]}}, load_byte};
         2'b01: load_data = unsigned_reg ? {16'd0, load_half}
                                         : {{16{load_half[15]}}, load_half};
         default: load_data = mem_read_data;
      endcase
   end

   // Store data replicated across lanes so each byte lane only needs an enable.
   always_comb begin
      case (size_reg)
         2'b00:   wdata_rep = {4{wdata_reg[7:0]}};
         2'b01:   wdata_rep = {2{wdata_reg[15:0]}};
         default: wdata_rep = wdata_reg;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign byte_en[gi] = (size_reg == 2'b00) ? (lane_reg == LANE)
                            : (size_reg == 2'b01) ? (lane_reg[1] == LANE[1])
                            : 1'b1;
         assign merge_data[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8]
                                                    : mem_read_data[8*gi +: 8];
      end
   endgenerate

   assign resp_valid     = (state_reg == RESP);
   assign MemRead        = !Reset && (state_reg == RD);
   assign MemWrite       = !Reset && (((state_reg == WAIT) && write_reg) || (state_reg == WR));
   assign mem_write_data = (state_reg == WAIT) ? merge_data : wdata_reg;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg    <= IDLE;
         write_reg    <= 1'b0;
         unsigned_reg <= 1'b0;
         size_reg     <= 2'b00;
         lane_reg     <= 2'b00;
         wdata_reg    <= 32'd0;
         mem_address  <= 32'd0;
         resp_rdata   <= 32'd0;
         resp_error   <= 1'b0;
         err_count    <= 8'd0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  write_reg    <= req_write;
                  unsigned_reg <= req_unsigned;
                  size_reg     <= req_size;
                  lane_reg     <= req_addr[1:0];
                  wdata_reg    <= req_wdata;
                  mem_address  <= {27'd0, req_addr[6:2]};
                  if (bad_req) begin
                     resp_rdata <= 32'd0;
                     resp_error <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
            end
            WAIT: begin
               resp_rdata <= write_reg ? 32'd0 : load_data;
               resp_error <= 1'b0;
            end
            WR: begin
               resp_rdata <= 32'd0;
               resp_error <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: requests push expected responses, a monitor
// pops and compares data, error flag, latency and strobe counts on every resp_valid.
module tb_mem_access_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic [7:0]  err_count;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        MemWrite, MemRead;

   mem_access_unit dut (
      .Clock(Clock), .Reset(Reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .err_count(err_count), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .MemWrite(MemWrite), .MemRead(MemRead),
      .mem_read_data(mem_read_data)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      int          rd0;
      int          wr0;
      int          nrd;
      int          nwr;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          overlap = 0;
   int          n_resp = 0;
   logic [31:0] mem [0:31];
   logic [31:0] ref_mem [0:31];

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      return (i == 5) ? 32'h8899AABB : {b, 8'hA5, b, 8'h5A};
   endfunction

   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] a);
      logic [31:0] s;
      logic [7:0]  b;
      logic [15:0] h;
      s = w >> (8 * a);
      b = s[7:0];
      h = a[1] ? w[31:16] : w[15:0];
      if (sz == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
      if (sz == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
      return w;
   endfunction

   function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] a, input logic [31:0] d);
      logic [31:0] m;
      if (sz == 2'b10) return d;
      if (sz == 2'b00) begin
         m = 32'hFF << (8 * a);
         return (w & ~m) | ((d & 32'hFF) << (8 * a));
      end
      m = 32'hFFFF << (16 * a[1]);
      return (w & ~m) | ((d & 32'hFFFF) << (16 * a[1]));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Data memory: registered read, write on the strobe edge.
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = init_word(i);
      mem_read_data = 32'd0;
      forever begin
         @(posedge Clock);
         if (MemRead)  mem_read_data <= mem[mem_address[4:0]];
         if (MemWrite) mem[mem_address[4:0]] <= mem_write_data;
      end
   end

   always @(posedge Clock) begin
      cyc++;
      if (MemRead)  rd_cnt++;
      if (MemWrite) wr_cnt++;
      if (MemRead && MemWrite) overlap++;
   end

   always @(negedge Clock) begin
      if (resp_valid) begin
         n_resp++;
         $display("resp %0d: cyc=%0d rdata=%h err=%b err_count=%0d",
                  n_resp, cyc, resp_rdata, resp_error, err_count);
         if (q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            chk("memread_count", 32'(rd_cnt - e.rd0), 32'(e.nrd));
            chk("memwrite_count", 32'(wr_cnt - e.wr0), 32'(e.nwr));
         end
      end
   end

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
      exp_t e;
      logic bad;
      int   n;
      int   lat;
      @(negedge Clock);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge Clock);
         n++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      bad = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
            (sz == 2'b10 && addr[1:0] != 2'b00) || (addr[31:7] != 25'd0);
      e.err = bad;
      e.rdata = (bad || wr) ? 32'd0 : exp_rd;
      if (bad)                  begin lat = 1; e.nrd = 0; e.nwr = 0; end
      else if (wr && sz == 2'b10) begin lat = 2; e.nrd = 0; e.nwr = 1; end
      else if (wr)              begin lat = 3; e.nrd = 1; e.nwr = 1; end
      else                      begin lat = 3; e.nrd = 1; e.nwr = 0; end
      e.cyc = cyc + lat;
      e.rd0 = rd_cnt;
      e.wr0 = wr_cnt;
      q.push_back(e);
      if (!bad && wr)
         ref_mem[addr[6:2]] = st_model(ref_mem[addr[6:2]], sz, addr[1:0], wd);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr;  req_wdata = wd;
      @(negedge Clock);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || !req_ready) && n < 50) begin
         @(negedge Clock);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      @(negedge Clock);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] a, w, ex;
      logic [1:0]  sz;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

      // Reset held with a pending request: it must not be accepted.
      Reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = 32'h08; req_wdata = 32'd0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_error", {31'd0, resp_error}, 32'd0);
      chk("reset_err_count", {24'd0, err_count}, 32'd0);
      chk("reset_mem_address", mem_address, 32'd0);
      chk("reset_mem_write_data", mem_write_data, 32'd0);
      chk("reset_memread", {31'd0, MemRead}, 32'd0);
      chk("reset_memwrite", {31'd0, MemWrite}, 32'd0);
      Reset = 1'b0; req_valid = 1'b0;
      repeat (4) @(negedge Clock);

      // Directed loads/stores on word 5 = 0x8899AABB and word 2.
      do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'd0, 32'hFFFFFFAA);
      do_req(1'b0, 2'b00, 1'b1, 32'h15, 32'd0, 32'h000000AA);
      do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234, 32'd0);
      wait_idle();
      chk("sh_word5", mem[5], 32'h1234AABB);
      do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 32'h00001234);
      do_req(1'b0, 2'b01, 1'b0, 32'h14, 32'd0, 32'hFFFFAABB);
      do_req(1'b0, 2'b10, 1'b1, 32'h14, 32'd0, 32'h1234AABB);
      do_req(1'b1, 2'b00, 1'b0, 32'h17, 32'h00000055, 32'd0);
      do_req(1'b0, 2'b00, 1'b0, 32'h17, 32'd0, 32'h00000055);
      do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'd0);
      wait_idle();
      chk("sw_word2", mem[2], 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 32'hDEADBEEF);

      // Rejected requests.
      do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 32'd0);
      do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 32'd0);
      do_req(1'b1, 2'b11, 1'b0, 32'h00, 32'h12345678, 32'd0);
      wait_idle();
      chk("err_count_4", {24'd0, err_count}, 32'd4);
      chk("err_no_mem_change", mem[0], ref_mem[0]);
      for (int i = 0; i < 296; i++) do_req(1'b0, 2'b11, 1'b0, 32'h04, 32'd0, 32'd0);
      wait_idle();
      chk("err_count_sat", {24'd0, err_count}, 32'd255);

      // Random aligned stream against the reference memory.
      for (int i = 0; i < 40; i++) begin
         sz = 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 127));
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz == 2'b10) a[1:0] = 2'b00;
         w  = $urandom;
         ex = ld_model(ref_mem[a[6:2]], sz, 1'($urandom_range(0, 1)), a[1:0]);
         if ($urandom_range(0, 1) == 1) do_req(1'b1, sz, 1'b0, a, w, 32'd0);
         else begin
            // Recompute with a fixed extension mode so expectation and request agree.
            ex = ld_model(ref_mem[a[6:2]], sz, 1'b0, a[1:0]);
            do_req(1'b0, sz, 1'b0, a, 32'd0, ex);
         end
      end
      wait_idle();

      // Reset during WAIT of a byte store abandons it.
      @(negedge Clock);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h14; req_wdata = 32'h55;
      @(negedge Clock);
      req_valid = 1'b0;
      n = 0;
      while (!MemRead && n < 10) begin
         @(negedge Clock);
         n++;
      end
      chk("abort_saw_memread", {31'd0, MemRead}, 32'd1);
      @(negedge Clock);
      Reset = 1'b1;
      #1;
      chk("abort_memwrite_low", {31'd0, MemWrite}, 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_err_count", {24'd0, err_count}, 32'd0);
      repeat (5) @(negedge Clock);
      chk("abort_word5", mem[5], ref_mem[5]);

      for (int i = 0; i < 32; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
      chk("strobe_overlap", 32'(overlap), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clock  in  1  single clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  1  CPU access request present.
REQ-004 req_ready  out  1  unit idle; request accepted at the edge where req_valid & req_ready.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-justified for byte/halfword.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  extended load data, valid with resp_valid.
REQ-012 resp_error  out  1  request rejected, valid with resp_valid.
REQ-013 err_count  out  8  count of rejected requests.
REQ-014 mem_address  out  32  word index to data memory, {27'b0, addr[6:2]}.
REQ-015 mem_write_data  out  32  word written to data memory.
REQ-016 MemWrite  out  1  data-memory write strobe.
REQ-017 MemRead  out  1  data-memory read strobe.
REQ-018 mem_read_data  in  32  data-memory output, valid the cycle after the edge that sampled MemRead.

Function
REQ-019 FSM states: IDLE, RD, WAIT, WR, RESP; req_ready = 1 only in IDLE.
REQ-020 Error on acceptance: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:7]!=0 (beyond 32 words).
REQ-021 IDLE transitions on accept: error -> RESP; load -> RD; word store -> WR; byte/halfword store -> RD. All request fields are registered at acceptance.
REQ-022 RD: MemRead=1 for exactly one cycle -> WAIT.
REQ-023 WAIT (load): capture extracted, extended data into resp_rdata -> RESP.
REQ-024 WAIT (sub-word store): MemWrite=1 with mem_write_data = mem_read_data, with the addressed lane replaced -> RESP.
REQ-025 WR: MemWrite=1, mem_write_data = req_wdata -> RESP.
REQ-026 RESP: resp_valid=1 for one cycle -> IDLE; no response backpressure.
REQ-027 Latency from accepting edge to resp_valid cycle: error 1, word store 2, load 3, sub-word store 3 cycles; back-to-back throughput is one request per latency+1 cycles.
REQ-028 Little-endian lanes: byte lane = addr[1:0], byte 0 = bits[7:0]; halfword lane = addr[1], half 0 = bits[15:0].
REQ-029 Word loads return the word unmodified, and req_unsigned has no effect on them.
REQ-030 MemRead and MemWrite are never high together, and both are low outside RD/WAIT/WR.
REQ-031 mem_address is held stable from RD through WAIT.
REQ-032 Error requests produce no memory strobes; resp_error=1 and resp_rdata=0 in RESP.
REQ-033 resp_error=0 for successful accesses, and resp_rdata=0 for stores.
REQ-034 err_count increments in the RESP cycle of an error and saturates at 255.
REQ-035 resp_rdata and resp_error hold their values outside RESP until the next response.

Reset
REQ-036 Reset sampled high -> next cycle: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, err_count=0, mem_address=0, mem_write_data=0.
REQ-037 MemRead and MemWrite are forced low combinationally while Reset is high, so no memory write occurs at the reset edge.
REQ-038 Reset mid-operation abandons the access: no strobe and no resp_valid for that request.
REQ-039 Reset has priority over a simultaneous req_valid; the request is not accepted.

Verification
REQ-040 Memory word 5 = 0x8899AABB. lb, addr 0x15 -> resp_rdata 0xFFFFFFAA, resp_error=0, resp_valid 3 cycles after accept; lbu -> 0x000000AA.
REQ-041 sh, wdata 0x00001234, addr 0x16, word 5 = 0x8899AABB -> one MemRead then one MemWrite of 0x1234AABB at word 5; lhu, addr 0x16 -> 0x00001234.
REQ-042 sw, wdata 0xDEADBEEF, addr 0x08 -> single MemWrite, mem_address 2, no MemRead, resp_valid 2 cycles after accept; lw, addr 0x08 -> 0xDEADBEEF.
REQ-043 Error cases: lw addr 0x13, lh addr 0x11, lw addr 0x80, size 11 -> no strobes, resp_error=1, resp_rdata=0, resp_valid 1 cycle after accept, err_count=4; 300 errors -> err_count=255.
REQ-044 sb, wdata 0x55, addr 0x14; Reset asserted during WAIT -> MemWrite stays low, word 5 unchanged, no resp_valid, req_ready=1 the cycle after reset.
REQ-045 Random load/store stream against a reference model -> memory contents and all resp_rdata match; MemRead and MemWrite are never high together.
